uart_tx_buffered: RTL and testbench

Buffered UART transmitter: accepts bytes from a host-side write strobe into an internal FIFO and serializes them 8N1 (optional parity) onto a single `tx` line, one bit per baud tick. It is paced by the `tx_clk_en` tick from the existing `baud_rate_genrator`. It is the transmit end facing an external receiver, and lets a host burst up to DEPTH bytes without polling `busy`.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 73 +++++++
 rtl/uart_tx_buffered.sv | 112 +++++++++++
 tb/tb_uart_tx_buffered.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter FSM encoding and frame lengths.
package uart_pkg;

    localparam int DATA_W           = 8;
    localparam int FRAME_LEN        = 10;
    localparam int FRAME_LEN_PARITY = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Parity over the data byte; odd parity is the inverted even parity.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a dropped-write pulse.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    // full/empty are registered, so a write while full is dropped even if a pop frees a slot that cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Next occupancy; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count + 1'b1;
            2'b01:   count_d = count - 1'b1;
            default: count_d = count;
        endcase
    end

    // Storage array, written at the write pointer
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and flags; reset discards all contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_d;
            full     <= (count_d == FULL_COUNT);
            empty    <= (count_d == '0);
            overflow <= push && full;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 (optional parity) UART transmitter paced by a baud tick.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   wr_en,
    input  logic                   tx_clk_en,
    output logic                   tx,
    output logic                   busy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              par_q, par_d;
    logic              tx_d;
    logic              pop;
    logic [DATA_W-1:0] head;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (data_in),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // Next-state logic advances only on baud ticks; tx is derived from the next state so the line is registered
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        par_d     = par_q;
        pop       = 1'b0;
        if (tx_clk_en) begin
            unique case (state_q)
                IDLE, STOP: begin
                    if (!empty) begin
                        shreg_d = head;
                        par_d   = parity_bit(head, PARITY_ODD != 0);
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
                DATA: begin
                    shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: state_d = STOP;
                default: state_d = IDLE;
            endcase
        end

        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    // State, shift register and registered line outputs; reset idles the line immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            par_q     <= par_d;
            tx        <= tx_d;
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for the buffered UART transmitter (no parity, even and odd parity instances).
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_gen = 1'b0;
    logic       tick_man = 1'b0;
    logic       tick;
    logic [7:0] din    [3];
    logic       wr     [3];
    logic       tx_o   [3];
    logic       busy_o [3];
    logic       full_o [3];
    logic       empty_o[3];
    logic       ovf_o  [3];
    logic [3:0] cnt_o  [3];

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    int         sel = 0;
    bit         auto_tick = 1'b0;
    int         div = 0;

    int          rx_state = 0;
    int          rx_bits = 0;
    logic [7:0]  rx_byte;
    int          frames = 0;
    int          idle_ticks = 0;
    int          busy_ticks = 0;
    logic        last_par = 1'b0;
    bit          burst_mode = 1'b0;
    int          burst_frames = 0;
    logic [10:0] frame_bits;
    int          frame_len = 0;

    assign tick = tick_gen | tick_man;

    always #5 clk = ~clk;

    uart_tx_buffered #(.DEPTH(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .wr_en(wr[0]), .tx_clk_en(tick),
        .tx(tx_o[0]), .busy(busy_o[0]), .full(full_o[0]), .empty(empty_o[0]),
        .count(cnt_o[0]), .overflow(ovf_o[0]));

    uart_tx_buffered #(.DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .wr_en(wr[1]), .tx_clk_en(tick),
        .tx(tx_o[1]), .busy(busy_o[1]), .full(full_o[1]), .empty(empty_o[1]),
        .count(cnt_o[1]), .overflow(ovf_o[1]));

    uart_tx_buffered #(.DEPTH(8), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .wr_en(wr[2]), .tx_clk_en(tick),
        .tx(tx_o[2]), .busy(busy_o[2]), .full(full_o[2]), .empty(empty_o[2]),
        .count(cnt_o[2]), .overflow(ovf_o[2]));

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got === expv) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic applyStimulus(input int s, input logic [7:0] d, input bit accept);
        @(posedge clk);
        #1;
        din[s] = d;
        wr[s]  = 1'b1;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic applyIdle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) wr[i] = 1'b0;
    endtask

    task automatic setTicks(input bit on);
        @(posedge clk);
        #1;
        auto_tick = on;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frames_done", frames, target);
    endtask

    // Baud tick every 16 clocks while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_tick) begin
                tick_gen = (div == 15);
                div      = (div == 15) ? 0 : div + 1;
            end else begin
                tick_gen = 1'b0;
                div      = 0;
            end
        end
    end

    // Line receiver: samples the selected DUT on each tick and scores frames against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_state   = 0;
                idle_ticks = 0;
            end else if (tick) begin
                case (rx_state)
                    0: begin
                        if (tx_o[sel] == 1'b0) begin
                            if (exp_q.size() > 0)
                                checkOutput("count_at_start", cnt_o[sel], exp_q.size() - 1);
                            if (burst_mode && burst_frames > 0)
                                checkOutput("gap_ticks", idle_ticks, 0);
                            rx_state   = 1;
                            rx_bits    = 0;
                            rx_byte    = '0;
                            busy_ticks = 0;
                            frame_bits = '0;
                            frame_len  = 1;
                        end else begin
                            idle_ticks++;
                        end
                    end
                    1: begin
                        rx_byte[rx_bits]      = tx_o[sel];
                        frame_bits[frame_len] = tx_o[sel];
                        frame_len++;
                        rx_bits++;
                        if (rx_bits == 8) rx_state = (sel != 0) ? 2 : 3;
                    end
                    2: begin
                        last_par              = tx_o[sel];
                        frame_bits[frame_len] = tx_o[sel];
                        frame_len++;
                        if (exp_q.size() > 0)
                            checkOutput("parity_bit", tx_o[sel], (^exp_q[0]) ^ (sel == 2));
                        rx_state = 3;
                    end
                    default: begin
                        frame_bits[frame_len] = tx_o[sel];
                        frame_len++;
                        checkOutput("stop_bit", tx_o[sel], 1);
                        checkOutput("sb_pending", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) checkOutput("frame_data", rx_byte, exp_q.pop_front());
                        frames++;
                        if (burst_mode) burst_frames++;
                        idle_ticks = 0;
                        rx_state   = 0;
                    end
                endcase
                if (busy_o[sel]) busy_ticks++;
            end
        end
    end

    initial begin
        int f0;
        int guard;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            wr[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", tx_o[0], 1);
        checkOutput("rst_busy", busy_o[0], 0);
        checkOutput("rst_full", full_o[0], 0);
        checkOutput("rst_empty", empty_o[0], 1);
        checkOutput("rst_count", cnt_o[0], 0);
        checkOutput("rst_overflow", ovf_o[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte 0xA5, no parity
        $display("[TB] single byte 0xA5");
        setTicks(1'b1);
        f0 = frames;
        applyStimulus(0, 8'hA5, 1'b1);
        applyIdle();
        waitFrames(f0 + 1, 400);
        repeat (40) @(negedge clk);
        checkOutput("a5_bits", frame_bits[9:0], 10'b1101001010);
        checkOutput("a5_len", frame_len, 10);
        checkOutput("a5_busy_ticks", busy_ticks, 10);
        checkOutput("a5_empty", empty_o[0], 1);
        checkOutput("a5_busy_low", busy_o[0], 0);

        // Burst of eight fills the FIFO, ninth write is dropped
        $display("[TB] burst and overflow");
        setTicks(1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 8'(i), 1'b1);
        applyStimulus(0, 8'hFF, 1'b0);
        @(negedge clk);
        checkOutput("burst_full", full_o[0], 1);
        checkOutput("burst_count", cnt_o[0], 8);
        checkOutput("ovf_before", ovf_o[0], 0);
        applyIdle();
        @(negedge clk);
        checkOutput("ovf_pulse", ovf_o[0], 1);
        checkOutput("full_held", full_o[0], 1);
        checkOutput("count_held", cnt_o[0], 8);
        @(negedge clk);
        checkOutput("ovf_clear", ovf_o[0], 0);
        f0           = frames;
        burst_mode   = 1'b1;
        burst_frames = 0;
        setTicks(1'b1);
        waitFrames(f0 + 8, 8 * 11 * 16 + 200);
        burst_mode = 1'b0;
        checkOutput("burst_sb_drained", exp_q.size(), 0);
        checkOutput("burst_empty", empty_o[0], 1);

        // Parity variants
        $display("[TB] parity even/odd");
        sel = 1;
        f0  = frames;
        applyStimulus(1, 8'h07, 1'b1);
        applyIdle();
        waitFrames(f0 + 1, 400);
        checkOutput("even_par_07", last_par, 1);
        checkOutput("even_len", frame_len, 11);
        repeat (40) @(negedge clk);
        sel = 2;
        f0  = frames;
        applyStimulus(2, 8'h07, 1'b1);
        applyIdle();
        waitFrames(f0 + 1, 400);
        checkOutput("odd_par_07", last_par, 0);
        checkOutput("odd_len", frame_len, 11);
        repeat (40) @(negedge clk);
        sel = 0;

        // Reset during D3 with two bytes queued
        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h3C, 1'b1);
        applyStimulus(0, 8'h11, 1'b1);
        applyStimulus(0, 8'h22, 1'b1);
        applyIdle();
        guard = 0;
        while (!(rx_state == 1 && rx_bits == 3) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_d3", guard < 2000, 1);
        @(posedge clk);
        #1;
        checkOutput("count_before_rst", cnt_o[0], 2);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_tx", tx_o[0], 1);
        checkOutput("rst_mid_busy", busy_o[0], 0);
        checkOutput("rst_mid_count", cnt_o[0], 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        f0  = frames;
        @(negedge clk);
        checkOutput("post_rst_empty", empty_o[0], 1);
        checkOutput("post_rst_count", cnt_o[0], 0);
        repeat (500) @(negedge clk);
        checkOutput("post_rst_no_frames", frames, f0);
        checkOutput("post_rst_tx_idle", tx_o[0], 1);

        // Write coinciding with a tick on an empty FIFO
        $display("[TB] write coincident with tick");
        setTicks(1'b0);
        f0 = frames;
        @(posedge clk);
        #1;
        din[0]   = 8'h5A;
        wr[0]    = 1'b1;
        tick_man = 1'b1;
        exp_q.push_back(8'h5A);
        @(posedge clk);
        #1;
        wr[0]    = 1'b0;
        tick_man = 1'b0;
        @(negedge clk);
        checkOutput("coin_count", cnt_o[0], 1);
        repeat (3) @(negedge clk);
        checkOutput("coin_no_start", tx_o[0], 1);
        checkOutput("coin_busy_low", busy_o[0], 0);
        @(posedge clk);
        #1;
        tick_man = 1'b1;
        @(posedge clk);
        #1;
        tick_man = 1'b0;
        checkOutput("coin_start_bit", tx_o[0], 0);
        checkOutput("coin_busy_high", busy_o[0], 1);
        auto_tick = 1'b1;
        waitFrames(f0 + 1, 400);
        checkOutput("final_sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
